mux10_rr_sequencer: RTL

//   Round-robin select sequencer that drives the 4-bit select of mux10.
//   It arbitrates among 10 requesters and drives sel to the mux for one settle cycle.
//   It then registers the mux output Z and presents it downstream with a valid/ready handshake.

---
 rtl/mux10_rr_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mux10_rr_sequencer.sv
// Round-robin select sequencer for a 10-input mux.
// Arbitrates among N_IN requesters and drives the mux select for one settle cycle.
// It then captures the mux output and holds it downstream until accepted.
module mux10_rr_sequencer #(
  parameter int N_IN   = 10,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req,
  output logic [N_IN-1:0]   gnt,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] z,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [SEL_W:0]   LP_N    = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(N_IN - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    r_sel;
  logic [N_IN-1:0]     r_gnt;
  logic [DATA_W-1:0]   r_out_data;
  logic [SEL_W-1:0]    r_out_src;
  logic                r_out_valid;
  logic [SEL_W:0]      w_pick;
  logic                w_found;
  logic [SEL_W-1:0]    w_idx;

  // First set request scanning p, p+1, ... modulo N_IN.
  // Result MSB is the "found" flag; the low bits hold the winning index.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_IN-1:0]  r,
                                             input logic [SEL_W-1:0] p);
    logic [SEL_W:0] c;
    logic [SEL_W:0] res;
    res = '0;
    for (int k = 0; k < N_IN; k++) begin
      c = {1'b0, p} + (SEL_W+1)'(k);
      if (c >= LP_N) c = c - LP_N;
      if (!res[SEL_W] && r[c[SEL_W-1:0]]) res = {1'b1, c[SEL_W-1:0]};
    end
    return res;
  endfunction

  assign w_pick  = rr_pick(req, r_ptr);
  assign w_found = w_pick[SEL_W];
  assign w_idx   = w_pick[SEL_W-1:0];

  // State register; a synchronous reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> SETTLE on any request, SETTLE -> HOLD always,
  // HOLD -> IDLE on downstream accept.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: grant/select in IDLE, capture z in SETTLE, release in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_sel       <= '0;
      r_gnt       <= '0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel <= w_idx;
            r_gnt <= N_IN'(1) << w_idx;
          end
        end
        SETTLE: begin
          // The grant is committed: capture regardless of req changes.
          r_out_data  <= z;
          r_out_src   <= r_sel;
          r_out_valid <= 1'b1;
          r_gnt       <= '0;
          r_ptr       <= (r_sel == LP_LAST) ? '0 : r_sel + 1'b1;
        end
        HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_gnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != IDLE);

endmodule
